// File: rtl/var_unpack_pkg.sv
// Shared widths and the field-mask helper for the variable-length bit unpacker.
package var_unpack_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BUF_W  = 64;
  localparam int unsigned PTR_W  = 6;
  localparam int unsigned LEN_W  = 7;

  // Ones in the low len bits; len >= WORD_W saturates to all ones.
  function automatic logic [WORD_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    if (len >= LEN_W'(WORD_W)) begin
      return {WORD_W{1'b1}};
    end
    return (WORD_W'(1) << len) - WORD_W'(1);
  endfunction

endpackage

// File: rtl/bit_window_rot.sv
// Combinational read window: rotate the circular bit buffer right by the read pointer
// and keep only the requested number of low bits.
module bit_window_rot
  import var_unpack_pkg::*;
(
  input  logic [BUF_W-1:0]  buf_data,
  input  logic [PTR_W-1:0]  rot,
  input  logic [PTR_W-1:0]  len,
  output logic [WORD_W-1:0] field
);

  logic [WORD_W-1:0] window;

  always_comb begin
    window = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      window[i] = buf_data[rot + PTR_W'(i)];
    end
    field = window & len_mask(LEN_W'(len));
  end

endmodule

// File: rtl/var_bit_unpacker.sv
// Variable-length LSB-first bit reader over a 64-bit circular buffer.
// Optional byte-align flush port pair is built when VAR_UNPACK_FLUSH_EN is defined.
module var_bit_unpacker #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BUF_W  = 64
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic                              in_valid,
  input  logic [WORD_W-1:0]                 in_data,
  output logic                              in_ready,
  input  logic                              rd_req,
  input  logic [var_unpack_pkg::PTR_W-1:0]  rd_len,
  output logic                              rd_ack,
  output logic [WORD_W-1:0]                 rd_data,
  output logic [var_unpack_pkg::LEN_W-1:0]  level,
  output logic                              err
`ifdef VAR_UNPACK_FLUSH_EN
  ,
  input  logic                              flush,
  output logic                              flush_ack
`endif
);

  import var_unpack_pkg::*;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic              len_ok, wr_en, flush_hit, flush_go;
  logic [2:0]        drop;
  logic [WORD_W-1:0] field;

  bit_window_rot u_rot (
    .buf_data (buf_q),
    .rot      (rd_ptr_q),
    .len      (rd_len),
    .field    (field)
  );

  // Bits needed to advance the read pointer to the next byte boundary.
  assign drop = 3'd0 - rd_ptr_q[2:0];

`ifdef VAR_UNPACK_FLUSH_EN
  assign flush_hit = flush;
  assign flush_go  = flush && (level_q >= LEN_W'(drop));
  assign flush_ack = flush_go;
`else
  assign flush_hit = 1'b0;
  assign flush_go  = 1'b0;
`endif

  assign len_ok   = ({1'b0, rd_len} <= LEN_W'(WORD_W));
  assign in_ready = (level_q <= LEN_W'(WORD_W));
  assign wr_en    = in_valid && in_ready;
  assign rd_ack   = rd_req && len_ok && (level_q >= LEN_W'(rd_len)) && !flush_hit;
  assign rd_data  = rd_ack ? field : '0;
  assign level    = level_q;
  assign err      = err_q;

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q | (rd_req && !len_ok);
    if (wr_en) begin
      for (int i = 0; i < int'(WORD_W); i++) begin
        buf_d[wr_ptr_q + PTR_W'(i)] = in_data[i];
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(WORD_W);
      level_d  = level_d + LEN_W'(WORD_W);
    end
    if (rd_ack) begin
      rd_ptr_d = rd_ptr_q + rd_len;
      level_d  = level_d - LEN_W'(rd_len);
    end
    if (flush_go) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(drop);
      level_d  = level_d - LEN_W'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      buf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_var_bit_unpacker.sv
// Randomised bench for var_bit_unpacker against a bit-queue reference model.
module tb_var_bit_unpacker;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        rd_req;
  logic [5:0]  rd_len;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [6:0]  level;
  logic        err;
  logic        flush;
`ifdef VAR_UNPACK_FLUSH_EN
  logic        flush_ack;
`endif

  var_bit_unpacker dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_req    (rd_req),
    .rd_len    (rd_len),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .level     (level),
    .err       (err)
`ifdef VAR_UNPACK_FLUSH_EN
    ,
    .flush     (flush),
    .flush_ack (flush_ack)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered bits, oldest first.
  bit          mq[$];
  bit          err_m;
  longint      consumed;
  int          n_checks;
  int          n_pass;
  logic [31:0] last_data;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_len = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    mq.delete();
    err_m    = 1'b0;
    consumed = 0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model.
  task automatic cycle(input bit v, input logic [31:0] d, input bit req, input int len,
                       input bit fl);
    int          n, drop;
    bit          erdy, eack, efack, fl_on;
    logic [31:0] ed;
    @(negedge clk);
    in_valid = v; in_data = d; rd_req = req; rd_len = 6'(len); flush = fl;
    #1;
    n     = mq.size();
    drop  = int'((8 - (consumed % 8)) % 8);
    fl_on = 1'b0;
    efack = 1'b0;
`ifdef VAR_UNPACK_FLUSH_EN
    fl_on = fl;
    efack = fl && (n >= drop);
`endif
    erdy = (n <= 32);
    eack = req && (len <= 32) && (n >= len) && !fl_on;
    ed   = '0;
    if (eack) for (int i = 0; i < len; i++) ed[i] = mq[i];
    check_eq("in_ready", 64'(in_ready), 64'(erdy));
    check_eq("rd_ack", 64'(rd_ack), 64'(eack));
    check_eq("rd_data", 64'(rd_data), 64'(ed));
    check_eq("level", 64'(level), 64'(n));
    check_eq("err", 64'(err), 64'(err_m));
`ifdef VAR_UNPACK_FLUSH_EN
    check_eq("flush_ack", 64'(flush_ack), 64'(efack));
`endif
    last_data = rd_data;
    if (req && len > 32) err_m = 1'b1;
    if (eack) begin
      for (int i = 0; i < len; i++) void'(mq.pop_front());
      consumed += len;
    end
    if (efack) begin
      for (int i = 0; i < drop; i++) void'(mq.pop_front());
      consumed += drop;
    end
    if (v && erdy) for (int i = 0; i < 32; i++) mq.push_back(d[i]);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset state
    do_reset();
    cycle(0, '0, 0, 0, 0);

    // Field split
    cycle(1, 32'hA5A5F00F, 0, 0, 0);
    cycle(0, '0, 1, 4, 0);
    check_eq("t2_f4", 64'(last_data), 64'h0F);
    cycle(0, '0, 1, 8, 0);
    check_eq("t2_f8", 64'(last_data), 64'h00);
    cycle(0, '0, 1, 20, 0);
    check_eq("t2_f20", 64'(last_data), 64'hA5A5F);
    cycle(0, '0, 0, 0, 0);

    // Full: third word held until a 32-bit read frees room
    cycle(1, 32'h11112222, 0, 0, 0);
    cycle(1, 32'h33334444, 0, 0, 0);
    cycle(1, 32'h55556666, 0, 0, 0);
    check_eq("t3_full_ready", 64'(in_ready), 64'd0);
    cycle(1, 32'h55556666, 1, 32, 0);
    check_eq("t3_rd32", 64'(last_data), 64'h11112222);
    cycle(1, 32'h55556666, 0, 0, 0);
    cycle(0, '0, 1, 32, 0);
    check_eq("t3_rd_w2", 64'(last_data), 64'h33334444);
    cycle(0, '0, 1, 12, 0);

    // Same-cycle write and read: level 20 -> 32, read returns old bits only
    cycle(1, 32'hFFFFFFFF, 1, 20, 0);
    check_eq("t4_old_bits", 64'(last_data), 64'h55556);
    cycle(0, '0, 0, 0, 0);
    check_eq("t4_level", 64'(level), 64'd32);

    // Underflow and sticky err
    cycle(0, '0, 1, 27, 0);
    cycle(0, '0, 1, 6, 0);
    check_eq("t5_underflow_ack", 64'(rd_ack), 64'd0);
    cycle(0, '0, 1, 33, 0);
    repeat (10) cycle(0, '0, 0, 0, 0);
    check_eq("t5_err_sticky", 64'(err), 64'd1);

`ifdef VAR_UNPACK_FLUSH_EN
    // Byte-align flush from rd_ptr=3, level=29; flush beats a pending read
    do_reset();
    cycle(1, 32'hCAFEBABE, 0, 0, 0);
    cycle(0, '0, 1, 3, 0);
    cycle(0, '0, 1, 8, 1);
    check_eq("t7_flush_ack", 64'(flush_ack), 64'd1);
    cycle(0, '0, 1, 8, 0);
    check_eq("t7_aligned", 64'(last_data), 64'hBA);
    check_eq("t7_level_after", 64'(level), 64'd24);
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bit fl;
      fl = 1'b0;
`ifdef VAR_UNPACK_FLUSH_EN
      fl = ($urandom_range(0, 19) == 0);
`endif
      cycle(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 32)), fl);
    end
    cycle(0, '0, 0, 0, 0);
    check_eq("wraps_ge_50", 64'(consumed / 64 >= 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
